// File: rtl/hl_display_pkg.sv
// Shared constants, segment patterns and display state encoding for the higher/lower result display.
package hl_display_pkg;

  localparam int unsigned CODE_W   = 4;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned AN_W     = 2;
  localparam int unsigned STREAK_W = 4;

  localparam logic [CODE_W-1:0]   CODE_LAST_DIGIT = 4'd9;
  localparam logic [CODE_W-1:0]   CODE_WIN        = 4'd10;
  localparam logic [CODE_W-1:0]   CODE_LOSE       = 4'd11;
  localparam logic [STREAK_W-1:0] STREAK_MAX      = 4'd9;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_P     = 7'h73;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h71;

  localparam logic [AN_W-1:0] AN_DIGIT0 = 2'b01;
  localparam logic [AN_W-1:0] AN_DIGIT1 = 2'b10;

  typedef enum logic [1:0] {
    ST_SHOW    = 2'd0,
    ST_RESULT  = 2'd1,
    ST_INVALID = 2'd2
  } state_e;

  // Display state implied by a game code
  function automatic state_e classify(input logic [CODE_W-1:0] code);
    if (code <= CODE_LAST_DIGIT) return ST_SHOW;
    if (code == CODE_WIN || code == CODE_LOSE) return ST_RESULT;
    return ST_INVALID;
  endfunction

endpackage

// File: rtl/hl_result_display_seg7_decode.sv
// Combinational game-code to active-high 7-segment pattern; unknown codes show a dash.
module seg7_decode
  import hl_display_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SEG_W-1:0]  seg_c_o
);

  always_comb begin
    seg_c_o = SEG_DASH;
    case (code_i)
      4'd0:    seg_c_o = SEG_0;
      4'd1:    seg_c_o = SEG_1;
      4'd2:    seg_c_o = SEG_2;
      4'd3:    seg_c_o = SEG_3;
      4'd4:    seg_c_o = SEG_4;
      4'd5:    seg_c_o = SEG_5;
      4'd6:    seg_c_o = SEG_6;
      4'd7:    seg_c_o = SEG_7;
      4'd8:    seg_c_o = SEG_8;
      4'd9:    seg_c_o = SEG_9;
      4'd10:   seg_c_o = SEG_P;
      4'd11:   seg_c_o = SEG_F;
      default: seg_c_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/hl_result_display.sv
// Higher/lower display back-end: digit decode, win/lose blink, win streak, optional two-digit mux.
// Define HL_DISPLAY_MUX_EN to multiplex the streak onto the second digit.
module hl_result_display
  import hl_display_pkg::*;
#(
  parameter int unsigned BLINK_HALF     = 5_000_000,
  parameter int unsigned CNT_W          = 23,
  parameter int unsigned MUX_PERIOD     = 50_000,
  parameter int unsigned MUX_W          = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] streak
);

  localparam logic [SEG_W-1:0] SEG_POL  = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [AN_W-1:0]  AN_POL   = SEG_ACTIVE_LOW ? {AN_W{1'b1}} : {AN_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  if (BLINK_HALF < 2 || MUX_PERIOD < 2 ||
      (64'd1 << CNT_W) <= 64'(BLINK_HALF) || (64'd1 << MUX_W) <= 64'(MUX_PERIOD)) begin : g_bad_cfg
    $error("hl_result_display: counter widths too small or periods below 2");
  end

  logic [CODE_W-1:0]   value_q, value_d;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [AN_W-1:0]     an_q, an_d;
  logic                entry_c;
  logic [SEG_W-1:0]    dec0_seg_c;
  logic [SEG_W-1:0]    digit0_seg_c;

  seg7_decode u_dec0 (.code_i(value_q), .seg_c_o(dec0_seg_c));

`ifdef HL_DISPLAY_MUX_EN
  logic [MUX_W-1:0] mux_cnt_q, mux_cnt_d;
  logic             sel_q, sel_d;
  logic [SEG_W-1:0] dec1_seg_c;

  seg7_decode u_dec1 (.code_i(streak_q), .seg_c_o(dec1_seg_c));
`endif

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q   <= '0;
      state_q   <= ST_SHOW;
      cnt_q     <= '0;
      phase_q   <= 1'b1;
      streak_q  <= '0;
      seg_q     <= SEG_BLANK ^ SEG_POL;
      an_q      <= AN_DIGIT0 ^ AN_POL;
`ifdef HL_DISPLAY_MUX_EN
      mux_cnt_q <= '0;
      sel_q     <= 1'b0;
`endif
    end else begin
      value_q   <= value_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      streak_q  <= streak_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
`ifdef HL_DISPLAY_MUX_EN
      mux_cnt_q <= mux_cnt_d;
      sel_q     <= sel_d;
`endif
    end
  end

  // Next state: entry detect, blink timing, streak, digit selection
  always_comb begin
    value_d      = value;
    state_d      = classify(value);
    entry_c      = (value != value_q) && (state_d == ST_RESULT);
    cnt_d        = '0;
    phase_d      = 1'b1;
    streak_d     = streak_q;
    digit0_seg_c = dec0_seg_c;
    seg_d        = seg_q;
    an_d         = an_q;

    // A steady result code keeps blinking; entry, exit and non-result codes restart at ON
    if (state_d == ST_RESULT && !entry_c) begin
      if (cnt_q == CNT_LAST) begin
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
      end
    end

    if (entry_c) begin
      if (value == CODE_WIN) begin
        streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + STREAK_W'(1);
      end else begin
        streak_d = '0;
      end
    end

    if (state_q == ST_RESULT && !phase_q) begin
      digit0_seg_c = SEG_BLANK;
    end

`ifdef HL_DISPLAY_MUX_EN
    mux_cnt_d = mux_cnt_q + MUX_W'(1);
    sel_d     = sel_q;
    if (mux_cnt_q == MUX_W'(MUX_PERIOD - 1)) begin
      mux_cnt_d = '0;
      sel_d     = ~sel_q;
    end
    seg_d = (sel_q ? dec1_seg_c : digit0_seg_c) ^ SEG_POL;
    an_d  = (sel_q ? AN_DIGIT1 : AN_DIGIT0) ^ AN_POL;
`else
    seg_d = digit0_seg_c ^ SEG_POL;
    an_d  = AN_DIGIT0 ^ AN_POL;
`endif
  end

  assign seg    = seg_q;
  assign an     = an_q;
  assign streak = streak_q;

endmodule

// File: tb/tb_hl_result_display.sv
// Directed scoreboard bench for hl_result_display (BLINK_HALF=4, MUX_PERIOD=3).
module tb_hl_result_display;

  localparam int unsigned BH = 4;
  localparam int unsigned MP = 3;

  typedef struct {
    int         due;
    int         kind;   // 0 seg, 1 streak, 2 an
    logic [6:0] exp;
    string      tag;
  } item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] value;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] streak;

  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;
  item_t sb[$];

  logic [3:0] m_val;
  int         m_k;
  int         m_streak;

  hl_result_display #(
    .BLINK_HALF    (BH),
    .CNT_W         (3),
    .MUX_PERIOD    (MP),
    .MUX_W         (2),
    .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .seg   (seg),
    .an    (an),
    .streak(streak)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] ref_decode(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;  4'd3: return 7'h4F;
      4'd4: return 7'h66;  4'd5: return 7'h6D;  4'd6: return 7'h7D;  4'd7: return 7'h07;
      4'd8: return 7'h7F;  4'd9: return 7'h6F;  4'd10: return 7'h73; 4'd11: return 7'h71;
      default: return 7'h40;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every scoreboard entry that has come due on this cycle
  task automatic score();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          0:       check(sb[i].tag, seg, sb[i].exp);
          1:       check(sb[i].tag, {3'b000, streak}, sb[i].exp);
          default: check(sb[i].tag, {5'b00000, an}, sb[i].exp);
        endcase
        sb.delete(i);
      end
    end
  endtask

  // Model: phase derived from cycles elapsed since entry into a result code
  task automatic model_push(input logic [3:0] v, input string tag);
    logic       res;
    logic [6:0] exp_seg;
    res = (v == 4'd10) || (v == 4'd11);
    if (res && v != m_val) begin
      m_k = 0;
      if (v == 4'd10) m_streak = (m_streak < 9) ? m_streak + 1 : 9;
      else            m_streak = 0;
    end
    m_val   = v;
    exp_seg = ref_decode(v);
    if (res) begin
      if (((m_k / BH) % 2) == 1) exp_seg = 7'h00;
      m_k++;
    end
    sb.push_back('{due: cyc + 1, kind: 1, exp: 7'(m_streak), tag: {tag, "/streak"}});
`ifndef HL_DISPLAY_MUX_EN
    sb.push_back('{due: cyc + 1, kind: 2, exp: 7'h01, tag: {tag, "/an"}});
    sb.push_back('{due: cyc + 2, kind: 0, exp: exp_seg, tag: {tag, "/seg"}});
`endif
  endtask

  task automatic step(input logic [3:0] v, input string tag);
    @(posedge clk);
    #1;
    score();
    value = v;
    model_push(v, tag);
  endtask

  task automatic model_reset();
    sb.delete();
    m_val    = 4'd0;
    m_k      = 0;
    m_streak = 0;
  endtask

  task automatic reset_pulse();
    #2;
    reset = 1'b1;
    value = 4'd0;
    #1;
    check("rst_mid/seg", seg, 7'h00);
    check("rst_mid/streak", {3'b000, streak}, 7'h00);
    check("rst_mid/an", {5'b00000, an}, 7'h01);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    value = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst/seg", seg, 7'h00);
    check("rst/an", {5'b00000, an}, 7'h01);
    check("rst/streak", {3'b000, streak}, 7'h00);
    @(negedge clk);
    reset = 1'b0;

    // Plain digit with two-cycle latency
    repeat (3) step(4'd7, "digit7");

    // Win held: blink P/blank, streak counted once
    repeat (20) step(4'd10, "win_hold");
    repeat (2) step(4'd5, "digit5");

    // Repeated wins saturate streak at 9, loss clears it
    for (int i = 0; i < 11; i++) begin
      step(4'd10, "win_seq");
      step(4'd5, "win_seq_gap");
    end
    repeat (2) step(4'd11, "lose_clear");

    // Win in its off phase jumps straight to lose: F with full ON phase
    repeat (7) step(4'd10, "win_off");
    repeat (9) step(4'd11, "lose_jump");

    // Invalid code shows dash, then reset lands mid-blink
    repeat (3) step(4'd13, "invalid");
    repeat (4) step(4'd10, "win_pre_rst");
    reset_pulse();
    repeat (3) step(4'd10, "win_post_rst");

`ifdef HL_DISPLAY_MUX_EN
    // Streak 3 on digit1, 8 on digit0, alternating every MUX_PERIOD cycles
    begin
      logic [1:0] a0;
      logic [1:0] prev;
      int         n;
      step(4'd5, "mux_gap");
      for (int i = 0; i < 2; i++) begin
        step(4'd10, "mux_win");
        step(4'd5, "mux_gap");
      end
      repeat (4) step(4'd8, "mux_digit8");
      prev = an;
      n    = 0;
      while (an === prev && n < 10) begin
        step(4'd8, "mux_sync");
        n++;
      end
      check("mux_sync_timeout", 7'(n < 10), 7'h01);
      a0 = an;
      for (int j = 0; j < 4 * MP; j++) begin
        logic [1:0] exp_an;
        if (j > 0) step(4'd8, "mux_run");
        exp_an = ((j / MP) % 2 == 0) ? a0 : ~a0;
        check("mux/an", {5'b00000, an}, {5'b00000, exp_an});
        check("mux/seg", seg, (exp_an == 2'b10) ? 7'h4F : 7'h7F);
      end
    end
`endif

    repeat (3) step(4'd0, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
